// File: rtl/kanagawa_hal_credit_issue_buffer_pkg.sv
// Shared types and elaboration helpers for the credit issue buffer.
package KanagawaTypes;

    localparam int KT_LOG_DEPTH = 5;
    localparam int KT_DEPTH     = 1 << KT_LOG_DEPTH;

    // Free-credit count: one extra bit so the full pool DEPTH is representable.
    typedef logic [KT_LOG_DEPTH:0] credit_t;

    // The credit pool and FIFO pointers rely on DEPTH being an exact power of two.
    function automatic bit depth_is_consistent(input int depth, input int log_depth);
        return depth == (1 << log_depth);
    endfunction

endpackage

// File: rtl/kanagawa_hal_credit_result_fifo.sv
// Show-ahead single-clock result FIFO. The head entry lives in a register so
// the output data is always registered; the RAM holds the entries behind it.
// A write arriving while full with no pop in the same cycle is dropped and
// flagged for one cycle on o_drop.
module kanagawa_hal_credit_result_fifo
    import KanagawaTypes::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 32,
    parameter int LOG_DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_drop
);

    localparam logic [LOG_DEPTH:0]   CNT_ONE  = (LOG_DEPTH+1)'(1);
    localparam logic [LOG_DEPTH:0]   CNT_FULL = (LOG_DEPTH+1)'(DEPTH);
    localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [LOG_DEPTH-1:0] r_wr_ptr;
    logic [LOG_DEPTH-1:0] r_rd_ptr;
    logic [LOG_DEPTH:0]   r_count;
    logic [WIDTH-1:0]     r_head;

    logic w_pop;
    logic w_full;
    logic w_write;
    logic w_head_bypass;
    logic w_head_from_ram;
    logic w_ram_write;

    assign w_pop   = (r_count != '0) && i_rd_en;
    assign w_full  = (r_count == CNT_FULL);
    assign w_write = i_wr_en && (!w_full || w_pop);
    assign o_drop  = i_wr_en && w_full && !w_pop;

    // The head is refilled straight from the write port when nothing sits
    // behind it; otherwise the next RAM entry moves up on a pop.
    assign w_head_bypass   = w_write && ((r_count == '0) || (w_pop && (r_count == CNT_ONE)));
    assign w_head_from_ram = w_pop && (r_count > CNT_ONE);
    assign w_ram_write     = w_write && !w_head_bypass;

    assign o_valid = (r_count != '0);
    assign o_data  = r_head;

    // Storage for entries queued behind the head (no reset, RAM-inferable).
    always_ff @(posedge clk) begin
        if (w_ram_write)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

    // Pointer, occupancy and head-register maintenance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_ram_write)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_head_from_ram) begin
                r_head   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else if (w_head_bypass) begin
                r_head <= i_wr_data;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/kanagawa_hal_credit_issue_buffer.sv
// Credit-gated front end for a non-stallable fixed-latency pipeline. A command
// is only accepted when a result slot is guaranteed, so downstream backpressure
// never loses results or over-consumes input.
module kanagawa_hal_credit_issue_buffer
    import KanagawaTypes::*;
#(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 16,
    parameter int DEPTH     = 32,
    parameter int LOG_DEPTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic [WIDTH_IN-1:0]  input_data,
    output logic                 issue_valid,
    output logic [WIDTH_IN-1:0]  issue_data,
    input  logic                 return_valid,
    input  logic [WIDTH_OUT-1:0] return_data,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic [WIDTH_OUT-1:0] output_data,
    output logic [LOG_DEPTH:0]   credits,
    output logic                 overflow_error
);

    if (!depth_is_consistent(DEPTH, LOG_DEPTH)) begin : g_bad_depth
        $error("DEPTH must equal 1 << LOG_DEPTH");
    end

    localparam logic [LOG_DEPTH:0] CREDIT_ONE  = (LOG_DEPTH+1)'(1);
    localparam logic [LOG_DEPTH:0] CREDIT_FULL = (LOG_DEPTH+1)'(DEPTH);

    logic [LOG_DEPTH:0] r_credits;
    logic               r_overflow;
    logic               w_accept;
    logic               w_pop;
    logic               w_out_valid;
    logic               w_drop;

    // Ready depends only on the credit register (and reset), never on valid.
    assign input_ready    = (r_credits != '0) && !rst;
    assign w_accept       = input_valid && input_ready;
    assign issue_valid    = w_accept;
    assign issue_data     = input_data;
    assign w_pop          = w_out_valid && output_ready;
    assign output_valid   = w_out_valid;
    assign credits        = r_credits;
    assign overflow_error = r_overflow;

    kanagawa_hal_credit_result_fifo #(
        .WIDTH     (WIDTH_OUT),
        .DEPTH     (DEPTH),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (return_valid),
        .i_wr_data (return_data),
        .i_rd_en   (output_ready),
        .o_valid   (w_out_valid),
        .o_data    (output_data),
        .o_drop    (w_drop)
    );

    // Credit pool: an accept consumes a slot, a pop frees one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= CREDIT_FULL;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_credits <= r_credits - CREDIT_ONE;
                2'b01:   r_credits <= r_credits + CREDIT_ONE;
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Sticky flag: a result was dropped because the FIFO was already full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
    end

endmodule

// File: doc/kanagawa_hal_credit_issue_buffer.md
# kanagawa_hal_credit_issue_buffer

Credit-gated front end for a non-stallable pipelined command processor. It consumes commands from an upstream ready/valid FIFO output and issues them into an external fixed-latency pipeline. Pipeline results are captured in an internal result FIFO that drives a ready/valid output. The block never accepts more commands than it has guaranteed result slots, so the downstream ready can stall indefinitely without losing or over-consuming input values.

## Interface
- WIDTH_IN, 16, command data width
- WIDTH_OUT, 16, result data width
- DEPTH, 32, result FIFO entries; also the total credit pool
- LOG_DEPTH, 5, log2(DEPTH); DEPTH must equal 1<<LOG_DEPTH

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- input_valid  in  1  upstream command valid
- input_ready  out  1  command accepted when input_valid && input_ready
- input_data  in  WIDTH_IN  command payload
- issue_valid  out  1  command entering external pipeline this cycle
- issue_data  out  WIDTH_IN  command payload to pipeline
- return_valid  in  1  pipeline result valid, one per issued command, any latency ≥1
- return_data  in  WIDTH_OUT  pipeline result payload
- output_valid  out  1  result available
- output_ready  in  1  downstream pop when output_valid && output_ready
- output_data  out  WIDTH_OUT  head-of-FIFO result
- credits  out  LOG_DEPTH+1  free credits
- overflow_error  out  1  sticky; return arrived with result FIFO full

## Operation
- Credit counter:
  - Resets to DEPTH.
  - Decrements by 1 on each accept (input_valid && input_ready).
  - Increments by 1 on each pop (output_valid && output_ready).
  - An accept and a pop in the same cycle leave it unchanged.
- Invariant: credits + in-flight commands + FIFO occupancy == DEPTH.
- input_ready = (credits != 0) && !rst. The ready path is combinational from the credits register only; it never depends on input_valid.
- issue_valid = input_valid && input_ready. issue_data = input_data (combinational pass-through).
- Result FIFO:
  - Show-ahead, DEPTH entries, pointers LOG_DEPTH bits, wrapping modulo DEPTH.
  - Occupancy counter is LOG_DEPTH+1 bits.
  - Every return_valid writes return_data.
  - A write while the FIFO is full, with no pop in the same cycle, is dropped and sets overflow_error. This can only occur if the external pipeline violates the one-result-per-issue rule.
  - Write and pop in the same cycle are legal at any occupancy, including full. When the FIFO is empty, the write wins and the entry appears the next cycle.
- overflow_error clears only on rst.
- Reset mid-operation:
  - Credits return to DEPTH, the FIFO empties, and the pointers zero.
  - return_valid pulses during rst are ignored.
  - The integrator must flush the external pipeline across reset. Returns arriving after rst deasserts count as writes.

## Timing
- Reset values: input_ready 0, issue_valid 0, output_valid 0, output_data 0, credits DEPTH, overflow_error 0.
- Accept → issue_valid: 0 cycles.
- return_valid at cycle t → output_valid at t+1, with output_data registered.
- Pop at cycle t → credits +1 visible at t+1, so input_ready can rise at t+1.
- Accept at cycle t → credits −1 at t+1. With credits == 1 at t, input_ready is 0 at t+1.
- Full credit loop with a 1-cycle pipeline and output_ready held high: sustains 1 command per cycle.
- output_valid/output_data stay stable while output_valid && !output_ready.

## Structure
- Shared package KanagawaTypes:
  - credit count typedef, logic [LOG_DEPTH:0]
  - a function checking that DEPTH == 1<<LOG_DEPTH, asserted at elaboration
- Sub-module kanagawa_hal_credit_result_fifo:
  - show-ahead single-clock FIFO with write-when-full drop flag
  - inferred RAM plus a registered head
- The top level holds the credit counter, the ready/issue logic and the sticky error flag.

## Test plan
- Reset: after rst deasserts → credits=32, input_ready=1, output_valid=0, overflow_error=0.
- Stall fill:
  - Stimulus: output_ready=0; offer 40 commands 0..39; pipeline latency 4 echoes data.
  - Required: exactly 32 accepted, input_ready=0 from the cycle after the 32nd accept, credits=0, no overflow_error.
- Drain/refill:
  - Stimulus: from the full state, pulse output_ready for 1 cycle.
  - Required: output_data=0 popped, credits=1 next cycle, exactly one further command (32) accepted, credits=0 again.
- Throughput:
  - Stimulus: latency 1, output_ready=1, 1000 back-to-back commands.
  - Required: 1 accept per cycle after the first result; outputs in order 0..999.
- Random stall:
  - Stimulus: 50000 commands; output_ready random with 2/3 duty; random pipeline latency 1..8, results kept in order.
  - Required: outputs exactly 0..49999; credits never exceeds 32; overflow_error stays 0.
- Fault and reset:
  - Stimulus: inject 33 return_valid pulses with output_ready=0.
  - Required: overflow_error=1 and 32 entries held.
  - Then assert rst mid-stream → all outputs return to their reset values within the same cycle, since reset is asynchronous.
